// File: rtl/hazard_ctrl_pkg.sv
// Shared types and defaults for the EX-stage hazard/sequencing controller.
package hazard_ctrl_pkg;
  localparam int INSTR_REG_BITS  = 5;
  localparam int MUL_LATENCY_DEF = 4;

  typedef enum logic {HZ_RUN, HZ_MUL} hz_state_t;
endpackage

// File: rtl/hazard_ctrl_raw_cmp.sv
// Combinational RAW compare: EX destination against ID sources, x0 never hits.
module hz_raw_cmp
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_BITS = INSTR_REG_BITS
) (
  input  logic [REG_BITS-1:0] rd,
  input  logic [REG_BITS-1:0] rs1,
  input  logic [REG_BITS-1:0] rs2,
  input  logic                uses_rs1,
  input  logic                uses_rs2,
  output logic                hit
);

  logic rd_nz;

  assign rd_nz = (rd != '0);
  assign hit   = rd_nz & ((uses_rs1 & (rs1 == rd)) | (uses_rs2 & (rs2 == rd)));

endmodule

// File: rtl/hazard_ctrl.sv
// EX-stage sequencing: load-use stall/bubble, multi-cycle MUL hold, branch flush.
// Optional saturating perf counters under `HAZARD_PERF_CNT_EN.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_BITS    = INSTR_REG_BITS,
  parameter int MUL_LATENCY = MUL_LATENCY_DEF,
  parameter int CNT_BITS    = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                id_valid_i,
  input  logic [REG_BITS-1:0] id_rs1_i,
  input  logic [REG_BITS-1:0] id_rs2_i,
  input  logic                id_uses_rs1_i,
  input  logic                id_uses_rs2_i,
  input  logic                id_is_mul_i,
  input  logic                ex_valid_i,
  input  logic [REG_BITS-1:0] ex_rd_i,
  input  logic                ex_is_ld_i,
  input  logic                ex_br_taken_i,
  output logic                if_stall_o,
  output logic                id_stall_o,
  output logic                ex_bubble_o,
  output logic                if_flush_o,
  output logic                id_flush_o,
  output logic                mul_start_o,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_BITS-1:0] perf_ldu_o,
  output logic [CNT_BITS-1:0] perf_mul_o,
  output logic [CNT_BITS-1:0] perf_flush_o,
`endif
  output logic                mul_busy_o
);

  localparam int CW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

  hz_state_t     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          raw_hit;
  logic          ldu;
  logic          ldu_stall;

  hz_raw_cmp #(.REG_BITS(REG_BITS)) u_raw_cmp (
    .rd       (ex_rd_i),
    .rs1      (id_rs1_i),
    .rs2      (id_rs2_i),
    .uses_rs1 (id_uses_rs1_i),
    .uses_rs2 (id_uses_rs2_i),
    .hit      (raw_hit)
  );

  assign ldu = ex_valid_i & ex_is_ld_i & id_valid_i & raw_hit;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= HZ_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    if_stall_o  = 1'b0;
    id_stall_o  = 1'b0;
    ex_bubble_o = 1'b0;
    if_flush_o  = 1'b0;
    id_flush_o  = 1'b0;
    mul_start_o = 1'b0;
    mul_busy_o  = 1'b0;
    ldu_stall   = 1'b0;
    unique case (state)
      HZ_RUN: begin
        if (ex_br_taken_i) begin
          if_flush_o = 1'b1;
          id_flush_o = 1'b1;
        end else if (ldu) begin
          ldu_stall   = 1'b1;
          if_stall_o  = 1'b1;
          id_stall_o  = 1'b1;
          ex_bubble_o = 1'b1;
        end else if (id_valid_i && id_is_mul_i) begin
          mul_start_o = 1'b1;
          cnt_nxt     = CW'(MUL_LATENCY - 2);
          state_nxt   = HZ_MUL;
        end
      end
      HZ_MUL: begin
        // Branch and load-use are ignored: EX is occupied by the MUL.
        mul_busy_o  = 1'b1;
        if_stall_o  = 1'b1;
        id_stall_o  = 1'b1;
        ex_bubble_o = 1'b1;
        if (cnt == '0) begin
          state_nxt = HZ_RUN;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = HZ_RUN;
    endcase
    // Outputs are forced low while in reset, even mid-sequence.
    if (!reset_n) begin
      if_stall_o  = 1'b0;
      id_stall_o  = 1'b0;
      ex_bubble_o = 1'b0;
      if_flush_o  = 1'b0;
      id_flush_o  = 1'b0;
      mul_start_o = 1'b0;
      mul_busy_o  = 1'b0;
      ldu_stall   = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_BITS-1:0] ldu_cnt, mul_cnt, flush_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ldu_cnt   <= '0;
      mul_cnt   <= '0;
      flush_cnt <= '0;
    end else begin
      if (ldu_stall && (ldu_cnt != '1))
        ldu_cnt <= ldu_cnt + CNT_BITS'(1);
      if ((mul_start_o || mul_busy_o) && (mul_cnt != '1))
        mul_cnt <= mul_cnt + CNT_BITS'(1);
      if (if_flush_o && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_BITS'(1);
    end
  end

  assign perf_ldu_o   = reset_n ? ldu_cnt   : '0;
  assign perf_mul_o   = reset_n ? mul_cnt   : '0;
  assign perf_flush_o = reset_n ? flush_cnt : '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed cases then randomized traffic vs a cycle-budget model.
module tb_hazard_ctrl;
  localparam int RB  = 5;
  localparam int LAT = 4;
  localparam int CB  = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          id_valid = 1'b0, id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, id_is_mul = 1'b0;
  logic [RB-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic          ex_valid = 1'b0, ex_is_ld = 1'b0, ex_br_taken = 1'b0;
  logic          if_stall, id_stall, ex_bubble, if_flush, id_flush, mul_start, mul_busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [CB-1:0] perf_ldu, perf_mul, perf_flush;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_BITS(RB), .MUL_LATENCY(LAT), .CNT_BITS(CB)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .id_valid_i    (id_valid),
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_uses_rs1_i (id_uses_rs1),
    .id_uses_rs2_i (id_uses_rs2),
    .id_is_mul_i   (id_is_mul),
    .ex_valid_i    (ex_valid),
    .ex_rd_i       (ex_rd),
    .ex_is_ld_i    (ex_is_ld),
    .ex_br_taken_i (ex_br_taken),
    .if_stall_o    (if_stall),
    .id_stall_o    (id_stall),
    .ex_bubble_o   (ex_bubble),
    .if_flush_o    (if_flush),
    .id_flush_o    (id_flush),
    .mul_start_o   (mul_start),
`ifdef HAZARD_PERF_CNT_EN
    .perf_ldu_o    (perf_ldu),
    .perf_mul_o    (perf_mul),
    .perf_flush_o  (perf_flush),
`endif
    .mul_busy_o    (mul_busy)
  );

  // Bit order: if_stall, id_stall, ex_bubble, if_flush, id_flush, mul_start, mul_busy
  typedef struct packed {
    logic [6:0]    ctl;
    logic [CB-1:0] p_ldu;
    logic [CB-1:0] p_mul;
    logic [CB-1:0] p_flush;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference: remaining MUL hold cycles plus event tallies.
  int   hold_left = 0;
  int   n_ldu = 0, n_mul = 0, n_flush = 0;

  task automatic step(input logic rst_n, input logic vld, input logic [RB-1:0] rs1,
                      input logic [RB-1:0] rs2, input logic u1, input logic u2,
                      input logic mul, input logic exv, input logic [RB-1:0] rd,
                      input logic ld, input logic br);
    exp_t e;
    logic hazard;
    @(posedge clk);
    #1;
    reset_n = rst_n; id_valid = vld; id_rs1 = rs1; id_rs2 = rs2;
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_is_mul = mul;
    ex_valid = exv; ex_rd = rd; ex_is_ld = ld; ex_br_taken = br;

    hazard = exv && ld && vld && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    e.ctl     = 7'b0;
    e.p_ldu   = rst_n ? CB'(n_ldu)   : '0;
    e.p_mul   = rst_n ? CB'(n_mul)   : '0;
    e.p_flush = rst_n ? CB'(n_flush) : '0;
    if (!rst_n) begin
      hold_left = 0;
      n_ldu = 0; n_mul = 0; n_flush = 0;
    end else if (hold_left > 0) begin
      e.ctl = 7'b1110001;
      hold_left--;
      n_mul++;
    end else if (br) begin
      e.ctl = 7'b0001100;
      n_flush++;
    end else if (hazard) begin
      e.ctl = 7'b1110000;
      n_ldu++;
    end else if (vld && mul) begin
      e.ctl = 7'b0000010;
      hold_left = LAT - 1;
      n_mul++;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    logic [6:0] got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {if_stall, id_stall, ex_bubble, if_flush, id_flush, mul_start, mul_busy};
        tests++;
        if (got !== e.ctl) begin
          fails++;
          $display("FAIL ctl t=%0t got=%b want=%b (ifs,ids,bub,iff,idf,start,busy)",
                   $time, got, e.ctl);
        end
`ifdef HAZARD_PERF_CNT_EN
        tests++;
        if ({perf_ldu, perf_mul, perf_flush} !== {e.p_ldu, e.p_mul, e.p_flush}) begin
          fails++;
          $display("FAIL perf t=%0t got ldu=%0d mul=%0d flush=%0d want ldu=%0d mul=%0d flush=%0d",
                   $time, perf_ldu, perf_mul, perf_flush, e.p_ldu, e.p_mul, e.p_flush);
        end
`endif
      end
    end
  end

  initial begin : stimulus
    int waited;
    // Reset state.
    repeat (3) step(1'b0, 1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1);
    idle();
    // Load-use on rs1, then bubble clears the load.
    step(1'b1, 1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0);
    step(1'b1, 1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    // Load into x0.
    step(1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0);
    // Unused rs2 operand matches.
    step(1'b1, 1'b1, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0);
    // Load-use on rs2.
    step(1'b1, 1'b1, 5'd3, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0);
    // MUL sequence, with branch/hazard/mul noise during the hold.
    step(1'b1, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    repeat (LAT - 1) step(1'b1, 1'b1, 5'd4, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b1);
    idle();
    // Branch outranks load-use and MUL start.
    step(1'b1, 1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b1);
    idle();
    // Reset mid-MUL, then a fresh MUL.
    step(1'b1, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    idle();
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    repeat (LAT) idle();
    // Randomized traffic over a small register window so hazards are frequent.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) != 0, 1'($urandom), RB'($urandom_range(0, 3)),
           RB'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
           $urandom_range(0, 5) == 0, 1'($urandom), RB'($urandom_range(0, 3)),
           1'($urandom), $urandom_range(0, 7) == 0);
    end
    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
